accumulator_5: RTL and testbench
================================

ACCUMULATOR_5 -- requirements
Module: accumulator_5

Interface
REQ-001 SHALL have parameter WIDTH, default 5, giving the operand and accumulator width in bits.
REQ-002 SHALL have parameter CNT_W, default 3, giving the operand-count width in bits (1..7 operands per job).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 start  input  1  begins a job; sampled in IDLE only.
REQ-006 len  input  CNT_W  number of operands in the job; sampled with start.
REQ-007 clear  input  1  synchronous abort to IDLE.
REQ-008 in_valid  input  1  in_data holds a valid operand.
REQ-009 in_ready  output  1  block accepts an operand this cycle.
REQ-010 in_data  input  WIDTH  operand.
REQ-011 out_valid  output  1  result and overflow are valid.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 result  output  WIDTH  accumulated sum, modulo 2^WIDTH.
REQ-014 overflow  output  1  sticky flag: any carry-out occurred during the job.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement the states IDLE, ACCUM and DONE.
REQ-017 IDLE behaviour:
- in_ready=0, out_valid=0.
- start=1 with len!=0: acc<=0, ovf<=0, remaining<=len, next state ACCUM.
- start=1 with len==0: acc<=0, ovf<=0, next state DONE.
REQ-018 ACCUM: in_ready=1; an operand transfers only on a cycle where in_valid=1 and in_ready=1.
REQ-019 On each transfer SHALL update:
- acc <= (acc + in_data) mod 2^WIDTH
- ovf <= ovf | carry-out
- remaining <= remaining - 1
REQ-020 Cycles in ACCUM with in_valid=0 SHALL leave acc, ovf and remaining unchanged.
REQ-021 A transfer with remaining==1 SHALL move the state to DONE; out_valid SHALL rise on the next cycle, giving a latency of 1 clock from the last operand.
REQ-022 DONE behaviour:
- out_valid=1, in_ready=0.
- result=acc, overflow=ovf.
- out_ready=1: next state IDLE.
REQ-023 While out_valid=1 and out_ready=0, result and overflow SHALL hold stable.
REQ-024 start SHALL be ignored in ACCUM and DONE.
REQ-025 clear=1 SHALL force IDLE, acc=0, ovf=0, remaining=0 from any state on the next edge.
REQ-026 clear SHALL take priority over start, over an operand transfer, and over a result transfer in the same cycle.
REQ-027 Outside DONE, result and overflow SHALL read 0.
REQ-028 Accumulation SHALL be unsigned, wrapping at 2^WIDTH; a carry-out on one operand only sets overflow and never alters result.
REQ-029 Wrap-around: 31 + 1 SHALL give result 0 with overflow 1.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge:
- force state IDLE
- clear acc, ovf and remaining to 0
- drive in_ready=0, out_valid=0, result=0, overflow=0, busy=0.
REQ-031 Reset asserted mid-job SHALL discard the job entirely; after release the block SHALL wait in IDLE for a new start.

Structure
REQ-032 A package accumulator_5_pkg SHALL hold:
- the state enum typedef (IDLE, ACCUM, DONE)
- the default WIDTH and CNT_W constants.
REQ-033 The sum and carry SHALL come from one combinational sub-module, ripple_carry_adder_5, with:
- operand a = acc, operand b = in_data
- sum and carry-out bit consumed by the accumulator.
REQ-034 No other sub-modules SHALL be used; the FSM and all registers live in accumulator_5.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Normal job: start with len=3; operands 5, 7, 9 with in_valid held high -> out_valid rises 1 cycle after the 3rd transfer, result=21, overflow=0.
- Overflow: len=2; operands 20, 15 -> result=3, overflow=1. Separately, len=2; operands 31, 1 -> result=0, overflow=1.
- Gaps and backpressure: len=2 with 3 idle in_valid=0 cycles between operands -> the idle cycles are not counted. Then hold out_ready=0 for 4 cycles with start pulsed -> result is stable, start is ignored, and the block returns to IDLE on the cycle after out_ready=1.
- Zero length: len=0 -> DONE on the next cycle with result=0, overflow=0.
- Abort and reset:
  - clear together with in_valid in ACCUM after one operand of 10 -> IDLE, busy=0, a new job with len=1 and operand 4 gives result 4.
  - rst_n=0 mid-ACCUM -> all outputs 0 immediately.

Source files
------------

// File: rtl/accumulator_5_pkg.sv
// Shared types and default sizes for the accumulator_5 block.
package accumulator_5_pkg;

    localparam int unsigned DefWidth = 5;
    localparam int unsigned DefCntW  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

endpackage

// File: rtl/ripple_carry_adder_5.sv
// Purely combinational ripple-carry adder: sum = a + b, carry = carry-out of the MSB.
module ripple_carry_adder_5
    import accumulator_5_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry-out
    logic [WIDTH:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign carry = c[WIDTH];

endmodule

// File: rtl/accumulator_5.sv
// Job-based unsigned accumulator: sums len operands, reports a wrapped result
// plus a sticky overflow flag through a valid/ready output handshake.
module accumulator_5
    import accumulator_5_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy
);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic             ovf_q;
    logic [CNT_W-1:0] remaining_q;

    logic [WIDTH-1:0] sum;
    logic             carry;

    ripple_carry_adder_5 #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (acc_q),
        .b     (in_data),
        .sum   (sum),
        .carry (carry)
    );

    // FSM and datapath registers; clear outranks every other action in the cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            remaining_q <= '0;
        end else if (clear) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            remaining_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                        if (len != '0) begin
                            remaining_q <= len;
                            state_q     <= StAccum;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StAccum: begin
                    // in_ready is implied high in this state
                    if (in_valid) begin
                        acc_q       <= sum;
                        ovf_q       <= ovf_q | carry;
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state, so reset zeroes them at once
    always_comb begin
        in_ready  = (state_q == StAccum);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        result    = (state_q == StDone) ? acc_q : '0;
        overflow  = (state_q == StDone) ? ovf_q : 1'b0;
    end

endmodule

// File: tb/tb_accumulator_5.sv
// Directed plus randomized self-checking bench for accumulator_5.
module tb_accumulator_5;

    localparam int unsigned WIDTH = 5;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             busy;

    int checks = 0;
    int errors = 0;

    accumulator_5 #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks every output against an expected snapshot
    task automatic check_outs(input string tag, input logic ev_in_ready, input logic ev_out_valid,
                              input logic ev_busy, input int ev_result, input logic ev_ovf);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(ev_in_ready));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ev_out_valid));
        check({tag, ".busy"}, 32'(busy), 32'(ev_busy));
        check({tag, ".result"}, 32'(result), 32'(ev_result));
        check({tag, ".overflow"}, 32'(overflow), 32'(ev_ovf));
    endtask

    // Reference: result is the true sum mod 2^WIDTH; a carry happened iff the true sum
    // ever reached 2^WIDTH, which for unsigned operands means the final true sum did.
    function automatic int model_result(input int total);
        return total % (1 << WIDTH);
    endfunction

    function automatic logic model_ovf(input int total);
        return total >= (1 << WIDTH);
    endfunction

    task automatic begin_job(input int n);
        start = 1'b1;
        len   = CNT_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input string tag, input int d);
        check({tag, ".ready_before_send"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = WIDTH'(d);
        tick();
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    int total;
    int n;
    int ops[$];
    logic [WIDTH-1:0] held_result;

    initial begin
        // Reset state
        tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_outs("idle_after_reset", 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Normal job: 5 + 7 + 9 with in_valid held high
        begin_job(3);
        check_outs("normal.accum", 1'b1, 1'b0, 1'b1, 0, 1'b0);
        in_valid = 1'b1;
        in_data  = 5'd5;
        tick();
        in_data = 5'd7;
        tick();
        check("normal.no_early_valid", 32'(out_valid), 32'd0);
        in_data = 5'd9;
        tick();
        in_valid = 1'b0;
        check_outs("normal.done", 1'b0, 1'b1, 1'b1, model_result(21), model_ovf(21));
        drain();
        check_outs("normal.back_idle", 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Overflow: 20 + 15 wraps to 3
        begin_job(2);
        send("ovf1.op0", 20);
        send("ovf1.op1", 15);
        check_outs("ovf1.done", 1'b0, 1'b1, 1'b1, 3, 1'b1);
        drain();

        // Wrap boundary: 31 + 1 gives 0 with overflow
        begin_job(2);
        send("ovf2.op0", 31);
        send("ovf2.op1", 1);
        check_outs("ovf2.done", 1'b0, 1'b1, 1'b1, 0, 1'b1);
        drain();

        // Gaps between operands are not counted
        begin_job(2);
        send("gap.op0", 6);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs("gap.idle", 1'b1, 1'b0, 1'b1, 0, 1'b0);
        end
        send("gap.op1", 11);
        check_outs("gap.done", 1'b0, 1'b1, 1'b1, 17, 1'b0);

        // Backpressure with start pulsed: result holds, start ignored
        held_result = result;
        for (int i = 0; i < 4; i++) begin
            start = (i % 2 == 0);
            len   = 3'd5;
            tick();
            check("bp.result_stable", 32'(result), 32'(held_result));
            check("bp.valid_held", 32'(out_valid), 32'd1);
            check("bp.ovf_held", 32'(overflow), 32'd0);
        end
        start = 1'b0;
        drain();
        check_outs("bp.released", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        tick();
        check("bp.start_ignored", 32'(busy), 32'd0);

        // Zero-length job goes straight to DONE
        begin_job(0);
        check_outs("zero.done", 1'b0, 1'b1, 1'b1, 0, 1'b0);
        drain();

        // Clear beats an operand transfer
        begin_job(3);
        send("clr.op0", 10);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 5'd3;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check_outs("clr.idle", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        begin_job(1);
        send("clr.new_op", 4);
        check_outs("clr.new_done", 1'b0, 1'b1, 1'b1, 4, 1'b0);

        // Clear beats a result transfer and a start in the same cycle
        clear     = 1'b1;
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 3'd2;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        start     = 1'b0;
        check_outs("clr_done.idle", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        tick();
        check("clr_done.start_dropped", 32'(busy), 32'd0);

        // Asynchronous reset mid-ACCUM zeroes outputs without a clock edge
        begin_job(4);
        send("rst.op0", 9);
        rst_n = 1'b0;
        #1;
        check_outs("rst.immediate", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check_outs("rst.waits_idle", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        begin_job(1);
        send("rst.new_op", 2);
        check_outs("rst.fresh_job", 1'b0, 1'b1, 1'b1, 2, 1'b0);
        drain();

        // Randomized jobs with random gaps and backpressure
        for (int j = 0; j < 40; j++) begin
            n = $urandom_range(0, 7);
            ops.delete();
            total = 0;
            for (int k = 0; k < n; k++) begin
                ops.push_back($urandom_range(0, 31));
                total += ops[k];
            end
            begin_job(n);
            for (int k = 0; k < n; k++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    in_data = WIDTH'($urandom);
                    tick();
                    check("rnd.gap_result_zero", 32'(result), 32'd0);
                end
                send("rnd.op", ops[k]);
            end
            for (int w = $urandom_range(0, 2); w >= 0; w--) begin
                check_outs("rnd.done", 1'b0, 1'b1, 1'b1, model_result(total), model_ovf(total));
                if (w > 0) tick();
            end
            drain();
            check("rnd.idle", 32'(busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
